// File: rtl/alu_share_pkg.sv
// Shared types and widths for the shared-ALU controller (perf counters via ALU_SHARE_PERF_EN).
package alu_share_pkg;

  localparam int DATA_W = 64;
  localparam int SEL_W  = 5;
  localparam int RES_W  = 128;
  localparam logic [SEL_W-1:0] LAST_OP = 5'd21;

  typedef enum logic [SEL_W-1:0] {
    ADD  = 5'd0,  SUB  = 5'd1,  MUL  = 5'd2,  DIV  = 5'd3,
    MOD  = 5'd4,  LOR  = 5'd5,  LAND = 5'd6,  NOTA = 5'd7,
    NOTB = 5'd8,  XOR  = 5'd9,  XNOR = 5'd10, NAND = 5'd11,
    NOR  = 5'd12, ROLA = 5'd13, RORA = 5'd14, ROLB = 5'd15,
    RORB = 5'd16, SHLA = 5'd17, SHRA = 5'd18, SHLB = 5'd19,
    SHRB = 5'd20, GT   = 5'd21
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

endpackage

// File: rtl/alu_share_rr_arb.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the one not served last.
module alu_share_rr_arb
  import alu_share_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_id,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_id ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between two requesters; operands are registered and held for a
// settle window before the result is sampled. Define ALU_SHARE_PERF_EN for perf counters.
module alu_share_ctrl #(
  parameter int DATA_W        = alu_share_pkg::DATA_W,
  parameter int SEL_W         = alu_share_pkg::SEL_W,
  parameter int RES_W         = alu_share_pkg::RES_W,
  parameter int SETTLE_CYCLES = 2,
  parameter logic [SEL_W-1:0] LAST_OP = alu_share_pkg::LAST_OP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [SEL_W-1:0]  req0_sel,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [SEL_W-1:0]  req1_sel,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic              rsp_err,
  output logic [RES_W-1:0]  rsp_data,
`ifdef ALU_SHARE_PERF_EN
  output logic [31:0]       perf_ops0,
  output logic [31:0]       perf_ops1,
  output logic [31:0]       perf_stall,
`endif
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [SEL_W-1:0]  alu_sel,
  input  logic [RES_W-1:0]  alu_c
);
  import alu_share_pkg::*;

  localparam int CNT_W = 4;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [SEL_W-1:0]  sel;
  } cmd_t;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             last_id_q;
  logic [1:0]       grant;
  cmd_t             cmd_g;
  logic             gnt_id, accept, illegal, rsp_hs;

  alu_share_rr_arb u_arb (
    .valid   ({req1_valid, req0_valid}),
    .last_id (last_id_q),
    .grant   (grant)
  );

  assign gnt_id     = grant[1];
  assign req0_ready = (state_q == ST_IDLE) && grant[0];
  assign req1_ready = (state_q == ST_IDLE) && grant[1];
  assign accept     = (state_q == ST_IDLE) && (|grant);
  assign cmd_g      = gnt_id ? {req1_a, req1_b, req1_sel} : {req0_a, req0_b, req0_sel};
  assign illegal    = cmd_g.sel > LAST_OP;
  assign rsp_hs     = rsp_valid && rsp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = illegal ? ST_RESP : ST_SETTLE;
      ST_SETTLE: if (cnt_q == '0) state_d = ST_RESP;
      ST_RESP:   if (rsp_hs) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Illegal ops enter RESP with rsp_valid still low; it rises on the first RESP cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      cnt_q     <= '0;
      last_id_q <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: if (accept) begin
          alu_a     <= cmd_g.a;
          alu_b     <= cmd_g.b;
          alu_sel   <= cmd_g.sel;
          last_id_q <= gnt_id;
          rsp_id    <= gnt_id;
          cnt_q     <= CNT_W'(SETTLE_CYCLES - 1);
          if (illegal) begin
            rsp_err  <= 1'b1;
            rsp_data <= '0;
          end
        end
        ST_SETTLE: begin
          if (cnt_q == '0) begin
            rsp_data  <= alu_c;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (!rsp_valid)    rsp_valid <= 1'b1;
          else if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_SHARE_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_ops0  <= '0;
      perf_ops1  <= '0;
      perf_stall <= '0;
    end else begin
      if (rsp_hs && !rsp_id)         perf_ops0  <= perf_ops0 + 32'd1;
      if (rsp_hs && rsp_id)          perf_ops1  <= perf_ops1 + 32'd1;
      if (rsp_valid && !rsp_ready)   perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: delayed behavioural ALU, transaction-level reference model,
// directed scenarios and a randomized phase. Perf checks compile in with ALU_SHARE_PERF_EN.
module tb_alu_share_ctrl;

  localparam int SETTLE = 2;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  sel;
  } cmd_t;

  typedef struct {
    logic         id;
    logic         err;
    logic [127:0] data;
    int           lat;
  } rsp_t;

  logic         clk, rst;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [63:0]  req0_a, req0_b, req1_a, req1_b;
  logic [4:0]   req0_sel, req1_sel;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [127:0] rsp_data;
  logic [63:0]  alu_a, alu_b;
  logic [4:0]   alu_sel;
  logic [127:0] alu_c;
`ifdef ALU_SHARE_PERF_EN
  logic [31:0]  perf_ops0, perf_ops1, perf_stall;
`endif

  alu_share_ctrl #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_err(rsp_err), .rsp_data(rsp_data),
`ifdef ALU_SHARE_PERF_EN
    .perf_ops0(perf_ops0), .perf_ops1(perf_ops1), .perf_stall(perf_stall),
`endif
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_c(alu_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic logic [127:0] alu_f(input logic [63:0] a, input logic [63:0] b, input logic [4:0] sel);
    logic [127:0] r;
    case (sel)
      5'd0:  r = {64'd0, a} + {64'd0, b};
      5'd1:  r = {64'd0, a - b};
      5'd2:  r = {64'd0, a} * {64'd0, b};
      5'd3:  r = (b == 0) ? 128'd0 : {64'd0, a / b};
      5'd4:  r = (b == 0) ? 128'd0 : {64'd0, a % b};
      5'd5:  r = {127'd0, (a != 0) || (b != 0)};
      5'd6:  r = {127'd0, (a != 0) && (b != 0)};
      5'd7:  r = {64'd0, ~a};
      5'd8:  r = {64'd0, ~b};
      5'd9:  r = {64'd0, a ^ b};
      5'd10: r = {64'd0, ~(a ^ b)};
      5'd11: r = {64'd0, ~(a & b)};
      5'd12: r = {64'd0, ~(a | b)};
      5'd13: r = {64'd0, (a << b[5:0]) | (a >> (7'd64 - {1'b0, b[5:0]}))};
      5'd14: r = {64'd0, (a >> b[5:0]) | (a << (7'd64 - {1'b0, b[5:0]}))};
      5'd15: r = {64'd0, (b << a[5:0]) | (b >> (7'd64 - {1'b0, a[5:0]}))};
      5'd16: r = {64'd0, (b >> a[5:0]) | (b << (7'd64 - {1'b0, a[5:0]}))};
      5'd17: r = {64'd0, a << b[5:0]};
      5'd18: r = {64'd0, a >> b[5:0]};
      5'd19: r = {64'd0, b << a[5:0]};
      5'd20: r = {64'd0, b >> a[5:0]};
      5'd21: r = {127'd0, a > b};
      default: r = 128'd0;
    endcase
    return r;
  endfunction

  // ALU with path delay: garbage until just before the sample edge.
  initial alu_c = '0;
  always @(alu_a or alu_b or alu_sel) begin
    alu_c = {4{32'hdead_beef}};
    #(SETTLE * 10 - 5);
    alu_c = alu_f(alu_a, alu_b, alu_sel);
  end

  cmd_t q0[$], q1[$];
  rsp_t rlog[$];
  logic hs0 = 1'b0, hs1 = 1'b0;

  // Requester driver: present queue heads, pop on handshake, garbage when idle.
  initial begin
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_sel = '0;
    req1_a = '0; req1_b = '0; req1_sel = '0;
    forever begin
      @(posedge clk); #1;
      if (hs0) begin q0.delete(0); hs0 = 1'b0; end
      if (hs1) begin q1.delete(0); hs1 = 1'b0; end
      if (q0.size() > 0) begin
        req0_valid = 1'b1; req0_a = q0[0].a; req0_b = q0[0].b; req0_sel = q0[0].sel;
      end else begin
        req0_valid = 1'b0; req0_a = {$urandom, $urandom}; req0_b = {$urandom, $urandom}; req0_sel = 5'($urandom);
      end
      if (q1.size() > 0) begin
        req1_valid = 1'b1; req1_a = q1[0].a; req1_b = q1[0].b; req1_sel = q1[0].sel;
      end else begin
        req1_valid = 1'b0; req1_a = {$urandom, $urandom}; req1_b = {$urandom, $urandom}; req1_sel = 5'($urandom);
      end
    end
  end

  // Reference model: one transaction in flight, a countdown to its response, a hold until taken.
  logic         m_busy, m_v, m_id, m_err, m_ill, m_last;
  int           m_wait;
  logic [63:0]  m_a, m_b;
  logic [4:0]   m_sel;
  logic [127:0] m_data;
  int unsigned  p0, p1, ps;
  int           acc_k, lat_cur;
  logic         prev_v;

  always @(negedge clk) begin
    logic e0, e1, pick;
    if (rst) begin
      m_busy = 0; m_v = 0; m_id = 0; m_err = 0; m_ill = 0; m_last = 1; m_wait = 0;
      m_a = '0; m_b = '0; m_sel = '0; m_data = '0;
      p0 = 0; p1 = 0; ps = 0; prev_v = 0; acc_k = 0; lat_cur = 0;
    end else begin
      e0 = !m_busy && req0_valid && (!req1_valid || m_last);
      e1 = !m_busy && req1_valid && (!req0_valid || !m_last);
      chk("req0_ready", req0_ready, e0);
      chk("req1_ready", req1_ready, e1);
      chk("rsp_valid", rsp_valid, m_v);
      if (m_v) begin
        chk("rsp_id", rsp_id, m_id);
        chk("rsp_err", rsp_err, m_err);
        chk("rsp_data", rsp_data, m_data);
      end
      chk("alu_a", alu_a, m_a);
      chk("alu_b", alu_b, m_b);
      chk("alu_sel", alu_sel, m_sel);
`ifdef ALU_SHARE_PERF_EN
      chk("perf_ops0", perf_ops0, p0);
      chk("perf_ops1", perf_ops1, p1);
      chk("perf_stall", perf_stall, ps);
`endif
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) acc_k = cyc + 1;
      if (rsp_valid && !prev_v) lat_cur = cyc - acc_k;
      prev_v = rsp_valid;
      if (rsp_valid && rsp_ready) rlog.push_back('{rsp_id, rsp_err, rsp_data, lat_cur});
      if (req0_valid && req0_ready) hs0 = 1'b1;
      if (req1_valid && req1_ready) hs1 = 1'b1;

      if (m_v) begin
        if (rsp_ready) begin
          if (m_id) p1++; else p0++;
          m_v = 0; m_busy = 0;
        end else ps++;
      end else if (m_busy) begin
        m_wait--;
        if (m_wait == 0) begin
          m_v = 1; m_err = m_ill;
          m_data = m_ill ? 128'd0 : alu_f(m_a, m_b, m_sel);
        end
      end else if (e0 || e1) begin
        pick = e1;
        m_a = pick ? req1_a : req0_a;
        m_b = pick ? req1_b : req0_b;
        m_sel = pick ? req1_sel : req0_sel;
        m_last = pick; m_id = pick; m_busy = 1;
        m_ill = m_sel > 5'd21;
        m_wait = m_ill ? 1 : SETTLE;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic wait_rsps(input int n, input string tag);
    int t = 0;
    while (rlog.size() < n && t < 300) begin tick(); t++; end
    if (rlog.size() < n) begin
      n_cmp++; n_err++;
      $display("FAIL %s timeout: actual %0d responses, required %0d", tag, rlog.size(), n);
    end
  endtask

  function automatic void chk_rsp(input string tag, input int i, input logic id, input logic err,
                                  input logic [127:0] data, input int lat);
    rsp_t r;
    r = (i < rlog.size()) ? rlog[i] : '{1'bx, 1'bx, 128'bx, -1};
    chk({tag, ".id"}, r.id, id);
    chk({tag, ".err"}, r.err, err);
    chk({tag, ".data"}, r.data, data);
    if (lat >= 0) chk({tag, ".lat"}, 128'(r.lat), 128'(lat));
  endfunction

  function automatic cmd_t rand_cmd();
    cmd_t c;
    c.a = {$urandom, $urandom};
    c.b = ($urandom_range(3) == 0) ? 64'($urandom_range(70)) : {$urandom, $urandom};
    c.sel = ($urandom_range(7) == 0) ? 5'($urandom_range(31, 22)) : 5'($urandom_range(21));
    return c;
  endfunction

  initial begin
    int t;
    rst = 1'b1; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.rsp_valid", rsp_valid, 0);
    chk("rst.rsp_id", rsp_id, 0);
    chk("rst.rsp_err", rsp_err, 0);
    chk("rst.rsp_data", rsp_data, 0);
    chk("rst.alu_a", alu_a, 0);
    chk("rst.alu_b", alu_b, 0);
    chk("rst.alu_sel", alu_sel, 0);
    rst = 1'b0;

    // Tie from reset: req0 first, then strict alternation.
    tick();
    q0.push_back('{64'd200, 64'd75, 5'd1}); q0.push_back('{64'd200, 64'd75, 5'd1});
    q1.push_back('{64'd500, 64'd500, 5'd4}); q1.push_back('{64'd500, 64'd500, 5'd4});
    wait_rsps(4, "tie");
    chk_rsp("tie0", 0, 1'b0, 1'b0, 128'd125, 2);
    chk_rsp("tie1", 1, 1'b1, 1'b0, 128'd0, 2);
    chk_rsp("tie2", 2, 1'b0, 1'b0, 128'd125, -1);
    chk_rsp("tie3", 3, 1'b1, 1'b0, 128'd0, -1);

    rlog.delete(); tick();
    q0.push_back('{64'd100, 64'd50, 5'd0});
    wait_rsps(1, "single");
    chk_rsp("single", 0, 1'b0, 1'b0, 128'd150, 2);

    // Back-pressure: response held, nobody accepted, ALU untouched.
    rlog.delete(); tick();
    rsp_ready = 1'b0;
    q0.push_back('{64'd12, 64'd10, 5'd9});
    t = 0;
    while (!rsp_valid && t < 50) begin tick(); t++; end
    q1.push_back('{64'd3, 64'd4, 5'd0});
    repeat (10) begin
      @(negedge clk);
      chk("bp.req0_ready", req0_ready, 0);
      chk("bp.req1_ready", req1_ready, 0);
      chk("bp.rsp_valid", rsp_valid, 1);
      chk("bp.rsp_data", rsp_data, 128'd6);
      chk("bp.alu_sel", alu_sel, 5'd9);
    end
    tick();
    rsp_ready = 1'b1;
    wait_rsps(2, "bp");
    chk_rsp("bp0", 0, 1'b0, 1'b0, 128'd6, -1);
    chk_rsp("bp1", 1, 1'b1, 1'b0, 128'd7, 2);

    rlog.delete(); tick();
    q1.push_back('{64'd1, 64'd2, 5'b10110});
    wait_rsps(1, "illegal");
    chk_rsp("illegal", 0, 1'b1, 1'b1, 128'd0, 1);
    q0.push_back('{64'd9, 64'd4, 5'd1});
    wait_rsps(2, "after_illegal");
    chk_rsp("after_illegal", 1, 1'b0, 1'b0, 128'd5, 2);

    // Reset one cycle into SETTLE: outputs clear at once, tie then goes to req0 again.
    rlog.delete(); tick();
    q0.push_back('{64'h1234, 64'd1, 5'd2});
    t = 0;
    while (q0.size() > 0 && t < 50) begin tick(); t++; end
    @(posedge clk); #3;
    rst = 1'b1; #1;
    chk("midrst.rsp_valid", rsp_valid, 0);
    chk("midrst.alu_a", alu_a, 0);
    chk("midrst.alu_sel", alu_sel, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    chk("midrst.nolog", 128'(rlog.size()), 0);
    q0.push_back('{64'd5, 64'd6, 5'd0});
    q1.push_back('{64'd7, 64'd7, 5'd1});
    wait_rsps(2, "rst_tie");
    chk_rsp("rst_tie0", 0, 1'b0, 1'b0, 128'd11, 2);
    chk_rsp("rst_tie1", 1, 1'b1, 1'b0, 128'd0, -1);

`ifdef ALU_SHARE_PERF_EN
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    rlog.delete(); tick();
    rsp_ready = 1'b0;
    repeat (3) q0.push_back('{64'd1, 64'd1, 5'd0});
    repeat (2) q1.push_back('{64'd2, 64'd1, 5'd1});
    t = 0;
    while (!rsp_valid && t < 50) begin tick(); t++; end
    repeat (4) tick();
    rsp_ready = 1'b1;
    wait_rsps(5, "perf");
    tick();
    chk("perf.ops0", perf_ops0, 3);
    chk("perf.ops1", perf_ops1, 2);
    chk("perf.stall", perf_stall, 4);
`endif

    repeat (3000) begin
      tick();
      if (q0.size() < 2 && $urandom_range(3) == 0) q0.push_back(rand_cmd());
      if (q1.size() < 2 && $urandom_range(3) == 0) q1.push_back(rand_cmd());
      rsp_ready = ($urandom_range(3) != 0);
    end
    rsp_ready = 1'b1;
    t = 0;
    while ((q0.size() > 0 || q1.size() > 0) && t < 200) begin tick(); t++; end
    if (q0.size() > 0 || q1.size() > 0) begin
      n_cmp++; n_err++;
      $display("FAIL drain timeout: actual %0d/%0d queued, required 0/0", q0.size(), q1.size());
    end
    repeat (20) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Sequencer/arbiter that shares the single 64-bit combinational ALU (operands a/b, 5-bit select, 128-bit result c) between two requesters.
- Accepts commands on two valid/ready ports and arbitrates them round-robin.
- Drives registered operands into the ALU and waits a fixed settle window, so gate-level/SDF path delay is tolerated.
- Captures the result and returns it with the requester ID on one response port.

Parameters:
- DATA_W, 64, operand width.
- SEL_W, 5, opcode width.
- RES_W, 128, ALU result width.
- SETTLE_CYCLES, 2, cycles operands are held before the result is sampled; legal range 1..15.
- LAST_OP, 5'd21, highest legal opcode; codes above it are illegal.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 command valid.
- req0_ready  out  1  requester 0 command accepted.
- req0_a  in  DATA_W  requester 0 operand A.
- req0_b  in  DATA_W  requester 0 operand B.
- req0_sel  in  SEL_W  requester 0 opcode.
- req1_valid, req1_ready, req1_a, req1_b, req1_sel: same as requester 0, for requester 1.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  1  requester that owns the response.
- rsp_err  out  1  illegal opcode flag.
- rsp_data  out  RES_W  captured ALU result.
- alu_a  out  DATA_W  registered operand A to the ALU.
- alu_b  out  DATA_W  registered operand B to the ALU.
- alu_sel  out  SEL_W  registered opcode to the ALU.
- alu_c  in  RES_W  ALU result.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE; rsp_valid=0; rsp_id=0; rsp_err=0; rsp_data=0; alu_a=0; alu_b=0; alu_sel=0; settle counter=0; last_id=1, so requester 0 wins the first tie.
- States: IDLE, SETTLE, RESP.
- Arbitration in IDLE:
  - grant = the only valid requester.
  - If both are valid, grant = !last_id.
  - reqN_ready = (state==IDLE) & grant==N; this is combinational from valid and last_id.
  - reqN_ready is 0 in every other state.
- Accept (handshake at edge k):
  - alu_a/alu_b/alu_sel <= granted operands; last_id <= granted ID; rsp_id <= granted ID.
  - If sel<=LAST_OP: go to SETTLE and load counter = SETTLE_CYCLES-1.
  - If sel>LAST_OP: go straight to RESP with rsp_err=1 and rsp_data=0. rsp_valid is high after edge k+1, and the ALU result is never sampled.
- SETTLE:
  - The counter decrements each cycle.
  - When the counter is 0: rsp_data <= alu_c, rsp_err <= 0, rsp_valid <= 1, go to RESP.
  - For a legal op, rsp_valid is high after edge k+SETTLE_CYCLES.
- RESP:
  - rsp_valid, rsp_id, rsp_err and rsp_data are held stable until rsp_valid & rsp_ready.
  - On that handshake: rsp_valid <= 0, go to IDLE.
  - No new accept happens in the handshake cycle.
  - Back-to-back throughput: one op per SETTLE_CYCLES+2 cycles when rsp_ready=1.
- alu_a/alu_b/alu_sel stay unchanged from accept until the next accept. The ALU is never disturbed mid-settle.
- Requester inputs are ignored when their ready is low; the requester must hold its command until the handshake.
- Widths: operands pass through unmodified, and the full RES_W result is captured. The controller applies no arithmetic to operands or result.
- Reset mid-operation: the in-flight op is dropped with no response, and all outputs go to their reset values immediately (asynchronous).

Optional Feature:
- Macro: ALU_SHARE_PERF_EN.
- When defined:
  - Adds outputs perf_ops0 and perf_ops1, 32 bits each, counting completed response handshakes per requester. Illegal-op responses are included.
  - Adds perf_stall, 32 bits, counting cycles with rsp_valid & !rsp_ready.
  - All three counters wrap at 2^32 and reset to 0.
- When undefined: none of these ports or registers exist; the rest of the behaviour is identical.

Decomposition:
- Shared package alu_share_pkg holds:
  - DATA_W, SEL_W, RES_W and LAST_OP.
  - An enumerated opcode type covering codes 0..21: ADD=0, SUB=1, MUL=2, DIV=3, MOD=4, LOR=5, LAND=6, NOTA=7, NOTB=8, XOR=9, XNOR=10, NAND=11, NOR=12, ROLA=13, RORA=14, ROLB=15, RORB=16, SHLA=17, SHRA=18, SHLB=19, SHRB=20, GT=21.
  - The state enum.
- One sub-module, alu_share_rr_arb: 2-way round-robin grant logic taking valids and last_id, producing the grant vector.

Test Plan:
- Single op: req0 {a=100, b=50, sel=0} with rsp_ready=1 -> rsp_valid after edge k+2, rsp_id=0, rsp_err=0, rsp_data=150 (behavioural ALU model).
- Tie: req0 {200,75,sel=1} and req1 {500,500,sel=4} valid in the same cycle from reset:
  - req0 granted first, rsp_data=125.
  - Then req1 granted, rsp_data=0, rsp_id=1.
  - With both held valid, grants alternate 0,1,0,1.
- Back-pressure: rsp_ready=0 for 10 cycles after rsp_valid -> rsp outputs stable, both reqN_ready=0, alu_sel unchanged. Raise rsp_ready -> one handshake, then IDLE.
- Illegal opcode: req1 sel=5'b10110 -> rsp_valid after edge k+1, rsp_err=1, rsp_data=0, rsp_id=1. The next legal op then completes normally.
- Reset mid-SETTLE: assert rst one cycle after accept -> rsp_valid=0 and alu_a=0 immediately. After release, req0 wins a tie.
- ALU_SHARE_PERF_EN: 3 ops from req0, 2 from req1, with 4 stall cycles -> perf_ops0=3, perf_ops1=2, perf_stall=4.
